// File: rtl/sc_regpath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sc_regpath_pkg (package)
//  Description : Shared definitions for the general-purpose register data path.
//                Holds the serial-writer state encoding and the default
//                data-bus width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sc_regpath_pkg;

    // Default width of the register data bus.
    localparam int unsigned c_DATAWIDTH_BUS_DEFAULT = 32;

    // Serial-writer frame state. The encoding is fixed because other blocks
    // in the data path decode it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2,
        ST_ERROR = 2'd3
    } sc_serwr_state_e;

endpackage
`default_nettype wire

// File: rtl/sc_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sc_gap_timer
//  Description : Saturating idle-gap timer. Counts enabled cycles since the
//                last clear and flags when the count has reached
//                TIMEOUT_CYCLES-1. The count never wraps.
//  Ports       : clk      - clock, posedge
//                rst_n    - asynchronous active-low reset
//                i_clear  - return count to zero (wins over i_enable)
//                i_enable - advance count by one
//                o_expire - count equals TIMEOUT_CYCLES-1
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_LAST = c_TW'(TIMEOUT_CYCLES - 1);

    logic [c_TW-1:0] timer_q;
    logic [c_TW-1:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (i_clear) begin
            timer_d = '0;
        end else if (i_enable && (timer_q != c_LAST)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign o_expire = (timer_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/sc_reg_serial_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sc_reg_serial_writer
//  Description : Write-side front end for a general-purpose register. Collects
//                a DATAWIDTH_BUS-bit word MSB first from a bit-serial link and
//                issues a one-cycle write strobe with the assembled word.
//                An inter-bit gap of TIMEOUT_CYCLES idle cycles aborts the
//                frame and raises a sticky error until the next start.
//  Ports       : SC_RegSERWR_CLOCK_50           - clock, posedge
//                SC_RegSERWR_Reset_InLow        - asynchronous active-low reset
//                SC_RegSERWR_Start_InHigh       - frame start pulse
//                SC_RegSERWR_SerialData_In      - serial data bit
//                SC_RegSERWR_SerialValid_InHigh - data bit valid
//                SC_RegSERWR_Write_OutHigh      - one-cycle register write strobe
//                SC_RegSERWR_DataBUS_Out        - assembled word (holds last write)
//                SC_RegSERWR_Busy_OutHigh       - frame in progress
//                SC_RegSERWR_Done_OutHigh       - pulse coincident with write
//                SC_RegSERWR_Error_OutHigh      - sticky gap-timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_reg_serial_writer
    import sc_regpath_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS  = c_DATAWIDTH_BUS_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     SC_RegSERWR_CLOCK_50,
    input  logic                     SC_RegSERWR_Reset_InLow,
    input  logic                     SC_RegSERWR_Start_InHigh,
    input  logic                     SC_RegSERWR_SerialData_In,
    input  logic                     SC_RegSERWR_SerialValid_InHigh,
    output logic                     SC_RegSERWR_Write_OutHigh,
    output logic [DATAWIDTH_BUS-1:0] SC_RegSERWR_DataBUS_Out,
    output logic                     SC_RegSERWR_Busy_OutHigh,
    output logic                     SC_RegSERWR_Done_OutHigh,
    output logic                     SC_RegSERWR_Error_OutHigh
);

    localparam int unsigned c_BW = $clog2(DATAWIDTH_BUS);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DATAWIDTH_BUS - 1);

    sc_serwr_state_e          state_q, state_d;
    // Only W-1 bits are stored: the final bit goes straight to the output word.
    logic [DATAWIDTH_BUS-2:0] shreg_q, shreg_d;
    logic [c_BW-1:0]          bitcnt_q, bitcnt_d;
    logic [DATAWIDTH_BUS-1:0] data_q, data_d;

    logic [DATAWIDTH_BUS-1:0] w_shifted;
    logic                     w_timer_clear;
    logic                     w_timer_enable;
    logic                     w_timer_expire;

    assign w_shifted = {shreg_q, SC_RegSERWR_SerialData_In};

    sc_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk      (SC_RegSERWR_CLOCK_50),
        .rst_n    (SC_RegSERWR_Reset_InLow),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_enable),
        .o_expire (w_timer_expire)
    );

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        bitcnt_d       = bitcnt_q;
        data_d         = data_q;
        // The timer only runs across idle cycles inside a frame.
        w_timer_clear  = 1'b1;
        w_timer_enable = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                if (SC_RegSERWR_Start_InHigh) begin
                    // Restart wins over a coincident valid bit; that bit is dropped.
                    shreg_d  = '0;
                    bitcnt_d = '0;
                end else if (SC_RegSERWR_SerialValid_InHigh) begin
                    shreg_d = w_shifted[DATAWIDTH_BUS-2:0];
                    if (bitcnt_q == c_BIT_LAST) begin
                        data_d  = w_shifted;
                        state_d = ST_WRITE;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end else begin
                    w_timer_clear  = 1'b0;
                    w_timer_enable = 1'b1;
                    if (w_timer_expire) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_IDLE, ST_WRITE, ST_ERROR: begin
                if (SC_RegSERWR_Start_InHigh) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = '0;
                    bitcnt_d = '0;
                end else if (state_q == ST_WRITE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SC_RegSERWR_CLOCK_50 or negedge SC_RegSERWR_Reset_InLow) begin
        if (!SC_RegSERWR_Reset_InLow) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
        end
    end

    // Status outputs are pure decodes of the state register, so an
    // asynchronous reset clears them without waiting for a clock edge.
    assign SC_RegSERWR_Write_OutHigh = (state_q == ST_WRITE);
    assign SC_RegSERWR_Done_OutHigh  = (state_q == ST_WRITE);
    assign SC_RegSERWR_Busy_OutHigh  = (state_q == ST_SHIFT) || (state_q == ST_WRITE);
    assign SC_RegSERWR_Error_OutHigh = (state_q == ST_ERROR);
    assign SC_RegSERWR_DataBUS_Out   = data_q;

endmodule
`default_nettype wire
